// File: rtl/ahb_pkg.sv
// Shared AHB-Lite types and constants for the register-file slave and its response FSM.
package ahb_pkg;

   typedef enum logic [1:0] {
      HTRANS_IDLE   = 2'b00,
      HTRANS_BUSY   = 2'b01,
      HTRANS_NONSEQ = 2'b10,
      HTRANS_SEQ    = 2'b11
   } htrans_t;

   typedef enum logic [2:0] {
      HSIZE_BYTE = 3'b000,
      HSIZE_HALF = 3'b001,
      HSIZE_WORD = 3'b010
   } hsize_t;

   localparam logic HRESP_OKAY  = 1'b0;
   localparam logic HRESP_ERROR = 1'b1;

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_WAIT = 3'd1,
      ST_DATA = 3'd2,
      ST_ERR1 = 3'd3,
      ST_ERR2 = 3'd4
   } state_t;

   // Byte lanes touched by an aligned access of the given size at the given lane.
   function automatic logic [3:0] lane_mask(input logic [2:0] size, input logic [1:0] lane);
      logic [3:0] mask;
      case (size)
         HSIZE_BYTE: mask = 4'b0001 << lane;
         HSIZE_HALF: mask = 4'b0011 << lane;
         HSIZE_WORD: mask = 4'b1111;
         default:    mask = 4'b0000;
      endcase
      return mask;
   endfunction

endpackage

// File: rtl/ahb_slave_resp_fsm.sv
// AHB-Lite slave response FSM: acceptance, error checks, wait-state counter,
// captured address phase and the write-commit / read-active strobes.
module ahb_slave_resp_fsm
   import ahb_pkg::*;
#(
   parameter  int DEPTH       = 64,
   parameter  int WAIT_STATES = 0,
   localparam int AW          = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          hsel,
   input  logic          hready,
   input  logic [1:0]    htrans,
   input  logic [31:0]   haddr,
   input  logic          hwrite,
   input  logic [2:0]    hsize,
   output logic          hreadyout,
   output logic          hresp,
   output logic          wr_commit,
   output logic          rd_active,
   output logic [AW-1:0] addr_q,
   output logic [2:0]    size_q
);

   state_t          state_r;
   logic [2:0]      cnt_r;
   logic            write_r;
   logic [AW-1:0]   addr_r;
   logic [2:0]      size_r;
   logic            hreadyout_r;
   logic            hresp_r;
   logic            accept_s;
   logic            err_s;

   // Transfer acceptance and address-phase error classification.
   always_comb begin
      accept_s = 1'b0;
      err_s    = 1'b0;
      if (hsel && hready && ((htrans == HTRANS_NONSEQ) || (htrans == HTRANS_SEQ))) begin
         accept_s = 1'b1;
      end else begin
         accept_s = 1'b0;
      end
      err_s = (hsize > HSIZE_WORD)
           || ((hsize == HSIZE_HALF) && haddr[0])
           || ((hsize == HSIZE_WORD) && (haddr[1:0] != 2'b00))
           || ((haddr >> AW) != 32'd0);
   end

   // Response FSM; HREADYOUT/HRESP are registered from the next state.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r     <= ST_IDLE;
         cnt_r       <= 3'd0;
         write_r     <= 1'b0;
         addr_r      <= {AW{1'b0}};
         size_r      <= 3'd0;
         hreadyout_r <= 1'b1;
         hresp_r     <= HRESP_OKAY;
      end else begin
         case (state_r)
            ST_IDLE, ST_DATA, ST_ERR2: begin
               if (accept_s) begin
                  addr_r  <= haddr[AW-1:0];
                  write_r <= hwrite;
                  size_r  <= hsize;
                  if (err_s) begin
                     state_r     <= ST_ERR1;
                     hreadyout_r <= 1'b0;
                     hresp_r     <= HRESP_ERROR;
                  end else if (WAIT_STATES == 0) begin
                     state_r     <= ST_DATA;
                     hreadyout_r <= 1'b1;
                     hresp_r     <= HRESP_OKAY;
                  end else begin
                     state_r     <= ST_WAIT;
                     cnt_r       <= 3'(WAIT_STATES - 1);
                     hreadyout_r <= 1'b0;
                     hresp_r     <= HRESP_OKAY;
                  end
               end else begin
                  state_r     <= ST_IDLE;
                  hreadyout_r <= 1'b1;
                  hresp_r     <= HRESP_OKAY;
               end
            end
            ST_WAIT: begin
               hresp_r <= HRESP_OKAY;
               if (cnt_r == 3'd0) begin
                  state_r     <= ST_DATA;
                  hreadyout_r <= 1'b1;
               end else begin
                  cnt_r       <= cnt_r - 3'd1;
                  hreadyout_r <= 1'b0;
               end
            end
            ST_ERR1: begin
               state_r     <= ST_ERR2;
               hreadyout_r <= 1'b1;
               hresp_r     <= HRESP_ERROR;
            end
            default: begin
               state_r     <= ST_IDLE;
               hreadyout_r <= 1'b1;
               hresp_r     <= HRESP_OKAY;
            end
         endcase
      end
   end

   assign hreadyout = hreadyout_r;
   assign hresp     = hresp_r;
   assign wr_commit = (state_r == ST_DATA) && write_r;
   assign rd_active = ((state_r == ST_WAIT) || (state_r == ST_DATA)) && !write_r;
   assign addr_q    = addr_r;
   assign size_q    = size_r;

endmodule

// File: rtl/ahb_regfile_slave.sv
// AHB-Lite byte-addressed register-file slave with wait states, lane steering
// and two-cycle ERROR responses.
module ahb_regfile_slave
   import ahb_pkg::*;
#(
   parameter int DEPTH       = 64,
   parameter int WAIT_STATES = 0
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        HSEL,
   input  logic [31:0] HADDR,
   input  logic [1:0]  HTRANS,
   input  logic        HWRITE,
   input  logic [2:0]  HSIZE,
   input  logic [31:0] HWDATA,
   input  logic        HREADY,
   output logic [31:0] HRDATA,
   output logic        HREADYOUT,
   output logic        HRESP
);

   localparam int AW = $clog2(DEPTH);

   logic [7:0]    mem_r [DEPTH];
   logic          wr_commit_s;
   logic          rd_active_s;
   logic [AW-1:0] addr_s;
   logic [AW-1:0] base_s;
   logic [2:0]    size_s;
   logic [3:0]    mask_s;
   logic [31:0]   rdata_s;

   ahb_slave_resp_fsm #(
      .DEPTH       (DEPTH),
      .WAIT_STATES (WAIT_STATES)
   ) u_fsm (
      .clk       (clk),
      .rst_n     (rst_n),
      .hsel      (HSEL),
      .hready    (HREADY),
      .htrans    (HTRANS),
      .haddr     (HADDR),
      .hwrite    (HWRITE),
      .hsize     (HSIZE),
      .hreadyout (HREADYOUT),
      .hresp     (HRESP),
      .wr_commit (wr_commit_s),
      .rd_active (rd_active_s),
      .addr_q    (addr_s),
      .size_q    (size_s)
   );

   // Word base of the captured address and the lanes the access covers.
   always_comb begin
      base_s = addr_s & ~(AW'(2'd3));
      mask_s = lane_mask(size_s, addr_s[1:0]);
   end

   // Byte storage; only the addressed lanes change on the final data-phase cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_r[i] <= 8'd0;
         end
      end else if (wr_commit_s) begin
         for (int n = 0; n < 4; n++) begin
            if (mask_s[n]) begin
               mem_r[base_s | AW'(n)] <= HWDATA[8*n +: 8];
            end
         end
      end
   end

   // Read lanes: addressed bytes during a read data phase, zero otherwise.
   always_comb begin
      rdata_s = 32'd0;
      for (int n = 0; n < 4; n++) begin
         if (rd_active_s && mask_s[n]) begin
            rdata_s[8*n +: 8] = mem_r[base_s | AW'(n)];
         end else begin
            rdata_s[8*n +: 8] = 8'd0;
         end
      end
   end

   assign HRDATA = rdata_s;

endmodule

// File: tb/tb_ahb_regfile_slave.sv
// Self-checking bench: two slaves (2 and 0 wait states) driven from vector tables,
// with a data-phase monitor comparing against an expectation queue per slave.
module tb_ahb_regfile_slave;
   import ahb_pkg::*;

   typedef struct {
      logic        write;
      logic [2:0]  size;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] rdata;
      logic        resp;
      int          waits;
      int          id;
   } vec_t;

   logic        clk = 1'b0;
   logic        rst_n_v     [2];
   logic        hsel_v      [2];
   logic [31:0] haddr_v     [2];
   logic [1:0]  htrans_v    [2];
   logic        hwrite_v    [2];
   logic [2:0]  hsize_v     [2];
   logic [31:0] hwdata_v    [2];
   logic        hready_v    [2];
   logic [31:0] hrdata_v    [2];
   logic        hreadyout_v [2];
   logic        hresp_v     [2];

   int   checks = 0;
   int   errors = 0;
   bit   done   = 1'b0;
   bit   in_dp  [2];
   int   waits_c[2];
   int   rd_idx [2];
   int   cyc    = 0;
   vec_t exp_q0[$];
   vec_t exp_q1[$];
   int   pipe_cyc[$];

   always #5 clk = ~clk;

   ahb_regfile_slave #(.DEPTH(64), .WAIT_STATES(2)) u_ws2 (
      .clk(clk), .rst_n(rst_n_v[0]), .HSEL(hsel_v[0]), .HADDR(haddr_v[0]),
      .HTRANS(htrans_v[0]), .HWRITE(hwrite_v[0]), .HSIZE(hsize_v[0]),
      .HWDATA(hwdata_v[0]), .HREADY(hready_v[0]), .HRDATA(hrdata_v[0]),
      .HREADYOUT(hreadyout_v[0]), .HRESP(hresp_v[0])
   );

   ahb_regfile_slave #(.DEPTH(64), .WAIT_STATES(0)) u_ws0 (
      .clk(clk), .rst_n(rst_n_v[1]), .HSEL(hsel_v[1]), .HADDR(haddr_v[1]),
      .HTRANS(htrans_v[1]), .HWRITE(hwrite_v[1]), .HSIZE(hsize_v[1]),
      .HWDATA(hwdata_v[1]), .HREADY(hready_v[1]), .HRDATA(hrdata_v[1]),
      .HREADYOUT(hreadyout_v[1]), .HRESP(hresp_v[1])
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   function automatic vec_t mk(input logic wr, input logic [2:0] sz, input logic [31:0] ad,
                               input logic [31:0] wd, input logic [31:0] rd,
                               input logic rs, input int wt, input int id);
      vec_t v;
      v.write = wr; v.size = sz; v.addr = ad; v.wdata = wd;
      v.rdata = rd; v.resp = rs; v.waits = wt; v.id = id;
      return v;
   endfunction

   function automatic int qsize(input int d);
      return (d == 0) ? exp_q0.size() : exp_q1.size();
   endfunction

   function automatic vec_t get_exp(input int d, input int idx);
      if (d == 0) return exp_q0[idx];
      return exp_q1[idx];
   endfunction

   task automatic drive_addr(input int d, input vec_t v);
      hsel_v[d]   = 1'b1;
      hready_v[d] = 1'b1;
      htrans_v[d] = HTRANS_NONSEQ;
      haddr_v[d]  = v.addr;
      hwrite_v[d] = v.write;
      hsize_v[d]  = v.size;
      if (d == 0) exp_q0.push_back(v);
      else        exp_q1.push_back(v);
   endtask

   task automatic drive_idle(input int d);
      hsel_v[d]   = 1'b0;
      htrans_v[d] = HTRANS_IDLE;
   endtask

   // One non-pipelined transfer; returns at posedge+1 after its data phase ends.
   task automatic xfer(input int d, input vec_t v);
      int n;
      drive_addr(d, v);
      @(posedge clk); #1;
      drive_idle(d);
      hwdata_v[d] = v.wdata;
      n = 0;
      while (in_dp[d] && n < 20) begin
         @(negedge clk); #1;
         n++;
      end
      if (n >= 20) begin
         checks++;
         errors++;
         $display("FAIL d%0d_v%0d_timeout: data phase still open after %0d cycles, required done", d, v.id, n);
      end
      @(posedge clk); #1;
   endtask

   // Data-phase monitor: counts wait cycles and compares the final cycle with the queue.
   task automatic monitor();
      vec_t cur;
      while (!done) begin
         @(negedge clk);
         cyc++;
         for (int d = 0; d < 2; d++) begin
            if (!rst_n_v[d]) begin
               in_dp[d] = 1'b0;
            end else begin
               if (in_dp[d]) begin
                  if (rd_idx[d] >= qsize(d)) begin
                     checks++;
                     errors++;
                     $display("FAIL d%0d_unexpected: data phase with no expectation queued", d);
                     in_dp[d] = 1'b0;
                  end else begin
                     cur = get_exp(d, rd_idx[d]);
                     if (!hreadyout_v[d]) begin
                        waits_c[d]++;
                        check($sformatf("d%0d_v%0d_resp_low", d, cur.id), 32'(hresp_v[d]), 32'(cur.resp));
                     end else begin
                        check($sformatf("d%0d_v%0d_rdata", d, cur.id), hrdata_v[d], cur.rdata);
                        check($sformatf("d%0d_v%0d_resp", d, cur.id), 32'(hresp_v[d]), 32'(cur.resp));
                        check($sformatf("d%0d_v%0d_waits", d, cur.id), 32'(waits_c[d]), 32'(cur.waits));
                        if (cur.id >= 100) pipe_cyc.push_back(cyc);
                        rd_idx[d]++;
                        in_dp[d] = 1'b0;
                     end
                  end
               end
               if (hreadyout_v[d] && hsel_v[d] && hready_v[d] && htrans_v[d][1]) begin
                  in_dp[d]   = 1'b1;
                  waits_c[d] = 0;
               end
            end
         end
      end
   endtask

   task automatic run();
      vec_t tab[18];
      vec_t pipe[4];

      tab[0]  = mk(1'b0, 3'b010, 32'h00, 32'h0,        32'h00000000, 1'b0, 2, 0);
      tab[1]  = mk(1'b1, 3'b010, 32'h04, 32'hDEADBEEF, 32'h00000000, 1'b0, 2, 1);
      tab[2]  = mk(1'b0, 3'b010, 32'h04, 32'h0,        32'hDEADBEEF, 1'b0, 2, 2);
      tab[3]  = mk(1'b1, 3'b000, 32'h06, 32'h00AA0000, 32'h00000000, 1'b0, 2, 3);
      tab[4]  = mk(1'b0, 3'b001, 32'h06, 32'h0,        32'hDEAA0000, 1'b0, 2, 4);
      tab[5]  = mk(1'b1, 3'b001, 32'h03, 32'hFFFFFFFF, 32'h00000000, 1'b1, 1, 5);
      tab[6]  = mk(1'b0, 3'b010, 32'h00, 32'h0,        32'h00000000, 1'b0, 2, 6);
      tab[7]  = mk(1'b0, 3'b010, 32'h40, 32'h0,        32'h00000000, 1'b1, 1, 7);
      tab[8]  = mk(1'b0, 3'b011, 32'h00, 32'h0,        32'h00000000, 1'b1, 1, 8);
      tab[9]  = mk(1'b1, 3'b010, 32'h22, 32'hFFFFFFFF, 32'h00000000, 1'b1, 1, 9);
      tab[10] = mk(1'b1, 3'b010, 32'h80000000, 32'h12345678, 32'h00000000, 1'b1, 1, 10);
      tab[11] = mk(1'b0, 3'b010, 32'h04, 32'h0,        32'hDEAABEEF, 1'b0, 2, 11);
      tab[12] = mk(1'b1, 3'b001, 32'h0A, 32'hCAFE0000, 32'h00000000, 1'b0, 2, 12);
      tab[13] = mk(1'b0, 3'b000, 32'h0B, 32'h0,        32'hCA000000, 1'b0, 2, 13);
      tab[14] = mk(1'b0, 3'b000, 32'h0A, 32'h0,        32'h00FE0000, 1'b0, 2, 14);
      tab[15] = mk(1'b1, 3'b000, 32'h3F, 32'h77000000, 32'h00000000, 1'b0, 2, 15);
      tab[16] = mk(1'b0, 3'b010, 32'h3C, 32'h0,        32'h77000000, 1'b0, 2, 16);
      tab[17] = mk(1'b0, 3'b010, 32'h20, 32'h0,        32'h00000000, 1'b0, 2, 17);

      pipe[0] = mk(1'b1, 3'b010, 32'h08, 32'h11223344, 32'h00000000, 1'b0, 0, 100);
      pipe[1] = mk(1'b0, 3'b010, 32'h08, 32'h0,        32'h11223344, 1'b0, 0, 101);
      pipe[2] = mk(1'b1, 3'b000, 32'h09, 32'h0000AB00, 32'h00000000, 1'b0, 0, 102);
      pipe[3] = mk(1'b0, 3'b010, 32'h08, 32'h0,        32'h1122AB44, 1'b0, 0, 103);

      repeat (2) @(posedge clk);
      #1;
      for (int d = 0; d < 2; d++) begin
         check($sformatf("d%0d_rst_ready", d), 32'(hreadyout_v[d]), 32'd1);
         check($sformatf("d%0d_rst_resp", d),  32'(hresp_v[d]),     32'd0);
         check($sformatf("d%0d_rst_rdata", d), hrdata_v[d],         32'd0);
         rst_n_v[d] = 1'b1;
      end
      @(posedge clk); #1;

      for (int i = 0; i < 18; i++) xfer(0, tab[i]);

      // Non-transfers must leave the slave ready and OKAY.
      hsel_v[0] = 1'b1; hready_v[0] = 1'b1; htrans_v[0] = HTRANS_IDLE;
      @(posedge clk); #1;
      check("idle_ready", 32'(hreadyout_v[0]), 32'd1);
      check("idle_resp",  32'(hresp_v[0]),     32'd0);
      htrans_v[0] = HTRANS_BUSY;
      @(posedge clk); #1;
      check("busy_ready", 32'(hreadyout_v[0]), 32'd1);
      check("busy_resp",  32'(hresp_v[0]),     32'd0);
      hsel_v[0] = 1'b0; htrans_v[0] = HTRANS_NONSEQ;
      @(posedge clk); #1;
      check("unsel_ready", 32'(hreadyout_v[0]), 32'd1);
      hsel_v[0] = 1'b1; hready_v[0] = 1'b0;
      @(posedge clk); #1;
      check("hready_low_ready", 32'(hreadyout_v[0]), 32'd1);
      hready_v[0] = 1'b1;
      drive_idle(0);
      @(posedge clk); #1;

      xfer(1, mk(1'b1, 3'b001, 32'h01, 32'hFFFFFFFF, 32'h00000000, 1'b1, 1, 50));
      for (int i = 0; i < 4; i++) begin
         drive_addr(1, pipe[i]);
         if (i > 0) hwdata_v[1] = pipe[i-1].wdata;
         @(posedge clk); #1;
      end
      drive_idle(1);
      hwdata_v[1] = pipe[3].wdata;
      repeat (3) @(posedge clk);
      #1;
      if (pipe_cyc.size() == 4) begin
         check("pipe_throughput", 32'(pipe_cyc[3] - pipe_cyc[0]), 32'd3);
      end else begin
         check("pipe_completions", 32'(pipe_cyc.size()), 32'd4);
      end
      xfer(1, mk(1'b0, 3'b010, 32'h08, 32'h0, 32'h1122AB44, 1'b0, 0, 51));

      // Reset asserted in the middle of a waited write.
      hsel_v[0] = 1'b1; hready_v[0] = 1'b1; htrans_v[0] = HTRANS_NONSEQ;
      haddr_v[0] = 32'h10; hwrite_v[0] = 1'b1; hsize_v[0] = 3'b010;
      @(posedge clk); #1;
      drive_idle(0);
      hwdata_v[0] = 32'h55555555;
      check("midwait_ready_low", 32'(hreadyout_v[0]), 32'd0);
      #2;
      rst_n_v[0] = 1'b0;
      #1;
      check("midwait_rst_ready", 32'(hreadyout_v[0]), 32'd1);
      check("midwait_rst_resp",  32'(hresp_v[0]),     32'd0);
      check("midwait_rst_rdata", hrdata_v[0],         32'd0);
      @(negedge clk);
      @(posedge clk); #1;
      rst_n_v[0] = 1'b1;
      @(posedge clk); #1;
      xfer(0, mk(1'b0, 3'b010, 32'h10, 32'h0, 32'h00000000, 1'b0, 2, 60));
      xfer(0, mk(1'b0, 3'b010, 32'h04, 32'h0, 32'h00000000, 1'b0, 2, 61));

      repeat (2) @(posedge clk);
      done = 1'b1;
   endtask

   initial begin
      for (int d = 0; d < 2; d++) begin
         rst_n_v[d]  = 1'b0;
         hsel_v[d]   = 1'b0;
         haddr_v[d]  = 32'd0;
         htrans_v[d] = HTRANS_IDLE;
         hwrite_v[d] = 1'b0;
         hsize_v[d]  = 3'b000;
         hwdata_v[d] = 32'd0;
         hready_v[d] = 1'b1;
         in_dp[d]    = 1'b0;
         waits_c[d]  = 0;
         rd_idx[d]   = 0;
      end
      fork
         monitor();
         run();
      join
      check("d0_all_done", 32'(rd_idx[0]), 32'(qsize(0)));
      check("d1_all_done", 32'(rd_idx[1]), 32'(qsize(1)));
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
